// File: rtl/parking_pkg.sv
// Shared constants and state encoding for the parking lot slot scheduler.
package parking_pkg;
   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 2;
   localparam int CAP_W     = 3;

   localparam logic [NUM_SLOTS-1:0] FULL_LOT = 4'b1111;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTRY_GATE = 2'd1,
      EXIT_GATE  = 2'd2
   } state_t;
endpackage

// File: rtl/parking_manager_slot_finder.sv
// Combinational free-slot summary: free count, lowest free index and full flag.
module slot_finder
   import parking_pkg::*;
(
   input  logic [NUM_SLOTS-1:0] occupancy,
   output logic [CAP_W-1:0]     capacity,
   output logic [SLOT_W-1:0]    nearest_park,
   output logic                 full
);

   always_comb begin
      capacity     = '0;
      nearest_park = '0;
      // Scan downward so the last hit left standing is the lowest free slot.
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!occupancy[i]) begin
            nearest_park = SLOT_W'(i);
            capacity     = capacity + CAP_W'(1);
         end
      end
      full = (occupancy == FULL_LOT);
   end

endmodule

// File: rtl/parking_manager.sv
// Slot scheduler: arbitrates entry/exit requests, tracks occupancy, times the gate.
module parking_manager #(
   parameter int NUM_SLOTS   = 4,
   parameter int GATE_CYCLES = 16
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         entry_req,
   input  logic                         exit_req,
   input  logic [parking_pkg::SLOT_W-1:0] exit_slot,
   output logic                         entry_ack,
   output logic                         entry_reject,
   output logic [parking_pkg::SLOT_W-1:0] assigned_slot,
   output logic                         exit_ack,
   output logic                         exit_err,
   output logic                         gate_open,
   output logic [NUM_SLOTS-1:0]         occupancy,
   output logic [parking_pkg::CAP_W-1:0] capacity,
   output logic [parking_pkg::SLOT_W-1:0] nearest_park
);
   import parking_pkg::*;

   localparam int TW = $clog2(GATE_CYCLES + 1);

   state_t              state, state_next;
   logic [TW-1:0]       timer, timer_next;
   logic [NUM_SLOTS-1:0] occ_next;
   logic [SLOT_W-1:0]   assigned_next;
   logic                entry_ack_next, entry_reject_next;
   logic                exit_ack_next, exit_err_next;
   logic                full;

   slot_finder u_finder (
      .occupancy    (occupancy),
      .capacity     (capacity),
      .nearest_park (nearest_park),
      .full         (full)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         timer         <= '0;
         occupancy     <= '0;
         assigned_slot <= '0;
         entry_ack     <= 1'b0;
         entry_reject  <= 1'b0;
         exit_ack      <= 1'b0;
         exit_err      <= 1'b0;
      end else begin
         state         <= state_next;
         timer         <= timer_next;
         occupancy     <= occ_next;
         assigned_slot <= assigned_next;
         entry_ack     <= entry_ack_next;
         entry_reject  <= entry_reject_next;
         exit_ack      <= exit_ack_next;
         exit_err      <= exit_err_next;
      end
   end

   always_comb begin
      state_next        = state;
      timer_next        = timer;
      occ_next          = occupancy;
      assigned_next     = assigned_slot;
      entry_ack_next    = 1'b0;
      entry_reject_next = 1'b0;
      exit_ack_next     = 1'b0;
      exit_err_next     = 1'b0;
      case (state)
         IDLE: begin
            // Exits win; a bogus exit still blocks the entry for this cycle.
            if (exit_req) begin
               if (occupancy[exit_slot]) begin
                  occ_next[exit_slot] = 1'b0;
                  exit_ack_next       = 1'b1;
                  timer_next          = TW'(GATE_CYCLES);
                  state_next          = EXIT_GATE;
               end else begin
                  exit_err_next = 1'b1;
               end
            end else if (entry_req) begin
               if (!full) begin
                  occ_next[nearest_park] = 1'b1;
                  assigned_next          = nearest_park;
                  entry_ack_next         = 1'b1;
                  timer_next             = TW'(GATE_CYCLES);
                  state_next             = ENTRY_GATE;
               end else begin
                  entry_reject_next = 1'b1;
               end
            end
         end
         ENTRY_GATE, EXIT_GATE: begin
            timer_next = timer - TW'(1);
            if (timer == TW'(1)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      gate_open = (state != IDLE);
   end

endmodule

// File: tb/tb_parking_manager.sv
// Bench for parking_manager: directed vector table, corner sequences, random vs model.
module tb_parking_manager;

   localparam int G = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       entry_req = 1'b0;
   logic       exit_req = 1'b0;
   logic [1:0] exit_slot = 2'd0;
   logic       entry_ack, entry_reject, exit_ack, exit_err, gate_open;
   logic [1:0] assigned_slot, nearest_park;
   logic [3:0] occupancy;
   logic [2:0] capacity;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: occupancy as a bit array plus remaining open cycles.
   bit m_occ[4];
   int m_gate_left;
   int m_asg;
   bit m_eack, m_erej, m_xack, m_xerr;

   parking_manager #(.NUM_SLOTS(4), .GATE_CYCLES(G)) dut (
      .CLK           (clk),
      .RST           (rst),
      .entry_req     (entry_req),
      .exit_req      (exit_req),
      .exit_slot     (exit_slot),
      .entry_ack     (entry_ack),
      .entry_reject  (entry_reject),
      .assigned_slot (assigned_slot),
      .exit_ack      (exit_ack),
      .exit_err      (exit_err),
      .gate_open     (gate_open),
      .occupancy     (occupancy),
      .capacity      (capacity),
      .nearest_park  (nearest_park)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int m_free();
      int c = 0;
      for (int i = 0; i < 4; i++) if (!m_occ[i]) c++;
      return c;
   endfunction

   function automatic int m_lowest();
      for (int i = 0; i < 4; i++) if (!m_occ[i]) return i;
      return 0;
   endfunction

   function automatic int m_occ_word();
      int w = 0;
      for (int i = 0; i < 4; i++) if (m_occ[i]) w += (1 << i);
      return w;
   endfunction

   task automatic model_edge(input bit r, input bit ent, input bit ext, input int slot);
      m_eack = 0; m_erej = 0; m_xack = 0; m_xerr = 0;
      if (r) begin
         for (int i = 0; i < 4; i++) m_occ[i] = 0;
         m_asg = 0;
         m_gate_left = 0;
      end else if (m_gate_left > 0) begin
         m_gate_left--;
      end else if (ext) begin
         if (m_occ[slot]) begin
            m_occ[slot] = 0; m_xack = 1; m_gate_left = G;
         end else begin
            m_xerr = 1;
         end
      end else if (ent) begin
         if (m_free() > 0) begin
            m_asg = m_lowest(); m_occ[m_asg] = 1; m_eack = 1; m_gate_left = G;
         end else begin
            m_erej = 1;
         end
      end
   endtask

   // One clock edge: advance the model with the current inputs, then compare.
   task automatic tick();
      bit r, e, x; int s;
      r = rst; e = entry_req; x = exit_req; s = int'(exit_slot);
      @(posedge clk);
      model_edge(r, e, x, s);
      #1;
      chk("m_entry_ack",    int'(entry_ack),     int'(m_eack));
      chk("m_entry_reject", int'(entry_reject),  int'(m_erej));
      chk("m_exit_ack",     int'(exit_ack),      int'(m_xack));
      chk("m_exit_err",     int'(exit_err),      int'(m_xerr));
      chk("m_gate_open",    int'(gate_open),     (m_gate_left > 0) ? 1 : 0);
      chk("m_occupancy",    int'(occupancy),     m_occ_word());
      chk("m_capacity",     int'(capacity),      m_free());
      chk("m_nearest_park", int'(nearest_park),  m_lowest());
      chk("m_assigned",     int'(assigned_slot), m_asg);
   endtask

   typedef struct {
      bit rst; bit ent; bit ext; logic [1:0] slot;
      bit eack; bit erej; bit xack; bit xerr; bit gate;
      logic [3:0] occ; logic [2:0] cap; logic [1:0] near; logic [1:0] asg;
      int gap;
   } vec_t;

   vec_t vecs[14];

   initial begin
      int cnt;
      //            rst ent ext slot eack erej xack xerr gate occ      cap near asg gap
      vecs[0]  = '{1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 4'b0000, 3'd4, 2'd0, 2'd0, 0};
      vecs[1]  = '{0, 1, 0, 2'd0, 1, 0, 0, 0, 1, 4'b0001, 3'd3, 2'd1, 2'd0, 16};
      vecs[2]  = '{0, 1, 0, 2'd0, 1, 0, 0, 0, 1, 4'b0011, 3'd2, 2'd2, 2'd1, 16};
      vecs[3]  = '{0, 1, 0, 2'd0, 1, 0, 0, 0, 1, 4'b0111, 3'd1, 2'd3, 2'd2, 16};
      vecs[4]  = '{0, 1, 0, 2'd0, 1, 0, 0, 0, 1, 4'b1111, 3'd0, 2'd0, 2'd3, 16};
      vecs[5]  = '{0, 1, 0, 2'd0, 0, 1, 0, 0, 0, 4'b1111, 3'd0, 2'd0, 2'd3, 0};
      vecs[6]  = '{0, 0, 1, 2'd1, 0, 0, 1, 0, 1, 4'b1101, 3'd1, 2'd1, 2'd3, 16};
      vecs[7]  = '{0, 1, 0, 2'd0, 1, 0, 0, 0, 1, 4'b1111, 3'd0, 2'd0, 2'd1, 16};
      vecs[8]  = '{0, 1, 1, 2'd0, 0, 0, 1, 0, 1, 4'b1110, 3'd1, 2'd0, 2'd1, 16};
      vecs[9]  = '{0, 1, 0, 2'd0, 1, 0, 0, 0, 1, 4'b1111, 3'd0, 2'd0, 2'd0, 16};
      vecs[10] = '{1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 4'b0000, 3'd4, 2'd0, 2'd0, 0};
      vecs[11] = '{0, 1, 0, 2'd0, 1, 0, 0, 0, 1, 4'b0001, 3'd3, 2'd1, 2'd0, 16};
      vecs[12] = '{0, 0, 1, 2'd2, 0, 0, 0, 1, 0, 4'b0001, 3'd3, 2'd1, 2'd0, 0};
      vecs[13] = '{0, 0, 1, 2'd0, 0, 0, 1, 0, 1, 4'b0000, 3'd4, 2'd0, 2'd0, 16};

      for (int v = 0; v < 14; v++) begin
         rst = vecs[v].rst; entry_req = vecs[v].ent;
         exit_req = vecs[v].ext; exit_slot = vecs[v].slot;
         tick();
         chk($sformatf("v%0d_entry_ack", v),    int'(entry_ack),     int'(vecs[v].eack));
         chk($sformatf("v%0d_entry_reject", v), int'(entry_reject),  int'(vecs[v].erej));
         chk($sformatf("v%0d_exit_ack", v),     int'(exit_ack),      int'(vecs[v].xack));
         chk($sformatf("v%0d_exit_err", v),     int'(exit_err),      int'(vecs[v].xerr));
         chk($sformatf("v%0d_gate_open", v),    int'(gate_open),     int'(vecs[v].gate));
         chk($sformatf("v%0d_occupancy", v),    int'(occupancy),     int'(vecs[v].occ));
         chk($sformatf("v%0d_capacity", v),     int'(capacity),      int'(vecs[v].cap));
         chk($sformatf("v%0d_nearest", v),      int'(nearest_park),  int'(vecs[v].near));
         chk($sformatf("v%0d_assigned", v),     int'(assigned_slot), int'(vecs[v].asg));
         rst = 0; entry_req = 0; exit_req = 0;
         for (int k = 0; k < vecs[v].gap; k++) begin
            tick();
            chk($sformatf("v%0d_gap%0d_gate", v, k), int'(gate_open), (k < G - 1) ? 1 : 0);
         end
      end

      // Simultaneous exit and held entry: entry lands G+1 cycles after the exit ack.
      entry_req = 1; tick(); entry_req = 0;
      for (int k = 0; k < G; k++) tick();
      entry_req = 1; exit_req = 1; exit_slot = 2'd0;
      tick();
      chk("both_exit_first", int'(exit_ack), 1);
      chk("both_no_entry",   int'(entry_ack), 0);
      exit_req = 0;
      cnt = 0;
      while (cnt < 40) begin
         tick();
         cnt++;
         if (entry_ack) break;
      end
      chk("both_entry_spacing", cnt, G + 1);
      chk("both_entry_slot", int'(assigned_slot), 0);
      entry_req = 0;
      for (int k = 0; k < G; k++) tick();

      // Reset in the middle of an entry window, timer at 5.
      entry_req = 1; tick(); entry_req = 0;
      chk("mid_ack", int'(entry_ack), 1);
      for (int k = 0; k < 11; k++) tick();
      chk("mid_gate_before", int'(gate_open), 1);
      rst = 1; tick(); rst = 0;
      chk("mid_gate_closed", int'(gate_open), 0);
      chk("mid_occ_lost", int'(occupancy), 0);
      chk("mid_capacity", int'(capacity), 4);

      // Random traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         rst       = ($urandom_range(0, 199) == 0);
         entry_req = ($urandom_range(0, 1) == 1);
         exit_req  = ($urandom_range(0, 2) == 0);
         exit_slot = 2'($urandom_range(0, 3));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/parking_manager.md
# parking_manager

Central slot scheduler for the 4-slot parking lot. It arbitrates entry and exit requests from the gate sensors and keeps the slot-occupancy register. It allocates the lowest-numbered free slot to each entering car and sequences the shared gate through a timed open window. It drives the free-slot count and nearest-free-slot index that the seven-segment display divider shows.

## Interface
Parameters:
- NUM_SLOTS, 4: number of parking slots; fixed at 4 for this lot (index width 2, count width 3).
- GATE_CYCLES, 16: cycles the gate stays open per granted request, ≥ 1.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  reset; synchronous, active-high.
- entry_req  in  1  car waiting at entry; level, held until entry_ack or entry_reject.
- exit_req  in  1  car leaving; level, held until exit_ack or exit_err.
- exit_slot  in  2  slot being vacated; valid while exit_req=1.
- entry_ack  out  1  one-cycle pulse when an entry is granted.
- entry_reject  out  1  one-cycle pulse when an entry is refused because the lot is full.
- assigned_slot  out  2  slot given to the last granted entry; held until the next grant.
- exit_ack  out  1  one-cycle pulse when an exit is granted.
- exit_err  out  1  one-cycle pulse when exit_slot is already free.
- gate_open  out  1  gate actuator; 1 during the open window.
- occupancy  out  4  bit i = slot i occupied.
- capacity  out  3  number of free slots, 0..4.
- nearest_park  out  2  lowest-index free slot; 0 when the lot is full.

## Operation
- FSM states: IDLE, ENTRY_GATE, EXIT_GATE.
- IDLE, arbitration in priority order:
  - exit_req=1 wins over entry_req=1.
  - Exit with occupancy[exit_slot]=1: clear that bit, pulse exit_ack, load the gate timer, go to EXIT_GATE.
  - Exit with occupancy[exit_slot]=0: pulse exit_err, leave occupancy unchanged, stay in IDLE. The pending entry is not serviced in that cycle.
  - Entry only, capacity>0: set occupancy[nearest_park], set assigned_slot to nearest_park, pulse entry_ack, load the gate timer, go to ENTRY_GATE.
  - Entry only, capacity=0: pulse entry_reject, stay in IDLE.
- ENTRY_GATE and EXIT_GATE:
  - gate_open=1 and the timer decrements each cycle.
  - When the timer reaches 1, return to IDLE; gate_open=0 in the following cycle.
  - All requests are ignored during these states. They stay pending because they are level-held.
- capacity and nearest_park are combinational from the occupancy register. capacity is the count of 0 bits. nearest_park is a priority encode of the lowest 0 bit, or 0 when occupancy=4'b1111.
- The display divider keys its "full" behaviour on capacity=0, not on nearest_park.
- Arithmetic: capacity is 3 bits, with 4 as the maximum. The timer is $clog2(GATE_CYCLES+1) bits. No wrap-around is possible.

## Timing
- Reset values: FSM=IDLE, occupancy=4'b0000, capacity=4, nearest_park=0, assigned_slot=0, gate_open=0, timer=0, all pulse outputs 0.
- Grant latency: a request sampled in IDLE on edge N is acknowledged by a pulse in cycle N+1. occupancy, capacity and nearest_park update in that same cycle N+1.
- gate_open is high for exactly GATE_CYCLES cycles, starting in the cycle of the ack pulse.
- Requester handshake: a requester drops its request in the cycle after it sees the ack. A request still asserted when the FSM returns to IDLE is treated as a new request.
- Back-to-back: minimum spacing between two grants is GATE_CYCLES+1 cycles.
- RST asserted mid-window: next edge gives reset values. Occupancy is lost and the gate closes immediately.

## Structure
- Package parking_pkg holds:
  - NUM_SLOTS=4, SLOT_W=2, CAP_W=3.
  - State encoding for IDLE, ENTRY_GATE and EXIT_GATE.
  - The full-lot constant 4'b1111.
- Sub-module slot_finder: combinational; maps occupancy[3:0] to capacity[2:0], nearest_park[1:0] and full.
- parking_manager contains the FSM, timer, occupancy register and pulse generation.

## Test plan
- Reset, then entry_req held → entry_ack 1 cycle later, assigned_slot=0, occupancy=0001, capacity=3, nearest_park=1, gate_open high for 16 cycles.
- Four entries in sequence → assigned_slot 0,1,2,3; capacity 3,2,1,0. A fifth entry → entry_reject, occupancy stays 1111, no gate_open.
- Occupancy=1111, exit_req with exit_slot=1 → exit_ack, occupancy=1101, capacity=1, nearest_park=1. The following entry gets slot 1.
- entry_req and exit_req (slot 0, occupied) asserted in the same cycle → exit_ack first. Entry is granted GATE_CYCLES+1 cycles later into slot 0.
- exit_req with exit_slot=2 while occupancy=0001 → exit_err pulse, occupancy unchanged, FSM stays in IDLE.
- RST asserted in ENTRY_GATE with timer at 5 → next cycle gate_open=0, occupancy=0000, capacity=4.
